reg_scoreboard: RTL and testbench

Tracks in-flight register writes in the LC-3b five-stage pipeline. It is the producer-side bookkeeping that complements data forwarding. The block shadows the destination register of every instruction in EX, MEM and WB, and keeps a per-register pending-write count. It asserts a decode-stage stall on a load-use hazard that forwarding cannot cover, and squashes shadow entries on a branch flush. It sits beside the ID/EX pipeline register and is driven by the same advance/flush controls as the datapath stage registers.

---
 rtl/reg_scoreboard_if.sv | 31 +++
 rtl/reg_scoreboard.sv | 53 +++++
 tb/tb_reg_scoreboard.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: decode-stage hazard inputs and shadow-pipeline outputs of the register scoreboard
interface reg_scoreboard_if;
   logic       advance;
   logic       flush;
   logic       id_valid;
   logic       id_reg_write;
   logic       id_mem_read;
   logic [2:0] id_dest;
   logic       id_use_sr1;
   logic       id_use_sr2;
   logic [2:0] id_sr1;
   logic [2:0] id_sr2;
   logic       stall_id;
   logic [7:0] pending;
   logic [2:0] ex_dest;
   logic [2:0] mem_dest;
   logic [2:0] wb_dest;
   logic       ex_wr;
   logic       mem_wr;
   logic       wb_wr;
   modport master (
      output advance, flush, id_valid, id_reg_write, id_mem_read, id_dest,
             id_use_sr1, id_use_sr2, id_sr1, id_sr2,
      input  stall_id, pending, ex_dest, mem_dest, wb_dest, ex_wr, mem_wr, wb_wr
   );
   modport slave (
      input  advance, flush, id_valid, id_reg_write, id_mem_read, id_dest,
             id_use_sr1, id_use_sr2, id_sr1, id_sr2,
      output stall_id, pending, ex_dest, mem_dest, wb_dest, ex_wr, mem_wr, wb_wr
   );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: shadows EX/MEM/WB destinations, counts pending writes per register, raises the load-use stall
module reg_scoreboard (
   input logic clk,
   input logic reset,
   reg_scoreboard_if.slave bus
);
   typedef struct packed {
      logic       valid;
      logic       reg_write;
      logic       mem_read;
      logic [2:0] dest;
   } slot_t;
   slot_t ex_q, mem_q, wb_q, id_s;
   logic [1:0] count [8];
   logic [3:0] nxt [8];
   logic load_use;
   always_comb begin
      load_use = ex_q.valid & ex_q.reg_write & ex_q.mem_read & bus.id_valid &
                 ((bus.id_use_sr1 & (bus.id_sr1 == ex_q.dest)) | (bus.id_use_sr2 & (bus.id_sr2 == ex_q.dest)));
      bus.stall_id = load_use & ~bus.flush;
      // bubbles are all-zero so debug dest outputs read 0 for empty slots
      id_s = (bus.id_valid & ~bus.stall_id) ? {1'b1, bus.id_reg_write, bus.id_mem_read, bus.id_dest} : '0;
      for (int r = 0; r < 8; r++) begin
         nxt[r] = {2'b00, count[r]}
                + 4'(~bus.flush & id_s.valid & id_s.reg_write & (id_s.dest == 3'(r)))
                - 4'(wb_q.valid & wb_q.reg_write & (wb_q.dest == 3'(r)))
                - 4'(bus.flush & ex_q.valid & ex_q.reg_write & (ex_q.dest == 3'(r)));
         bus.pending[r] = count[r] != 2'd0;
      end
   end
   assign bus.ex_dest  = ex_q.dest;
   assign bus.mem_dest = mem_q.dest;
   assign bus.wb_dest  = wb_q.dest;
   assign bus.ex_wr    = ex_q.valid & ex_q.reg_write;
   assign bus.mem_wr   = mem_q.valid & mem_q.reg_write;
   assign bus.wb_wr    = wb_q.valid & wb_q.reg_write;
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
         count <= '{default: 2'd0};
      end else if (bus.advance) begin
         wb_q  <= mem_q;
         mem_q <= bus.flush ? '0 : ex_q;
         ex_q  <= bus.flush ? '0 : id_s;
         for (int r = 0; r < 8; r++) begin
            assert (nxt[r] <= 4'd3);
            count[r] <= nxt[r][1:0];
         end
      end
   end
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed hazard scenarios plus random traffic against a stage-list model of the pipeline
module tb_reg_scoreboard;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic armed = 1'b0;
   int errors = 0;
   int checks = 0;
   always #5 clk = ~clk;
   reg_scoreboard_if bus();
   reg_scoreboard dut (.clk(clk), .reset(reset), .bus(bus.slave));
   // model: index 0 = EX, 1 = MEM, 2 = WB
   logic       mv [3];
   logic       mw [3];
   logic       ml [3];
   logic [2:0] md [3];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic logic exp_stall();
      return !bus.flush && mv[0] && mw[0] && ml[0] && bus.id_valid &&
             ((bus.id_use_sr1 && bus.id_sr1 == md[0]) || (bus.id_use_sr2 && bus.id_sr2 == md[0]));
   endfunction
   // a register is pending when any live writer in EX/MEM/WB targets it
   function automatic logic [7:0] exp_pending();
      logic [7:0] p = '0;
      for (int s = 0; s < 3; s++) if (mv[s] && mw[s]) p[md[s]] = 1'b1;
      return p;
   endfunction
   always @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < 3; s++) begin
            mv[s] <= 1'b0; mw[s] <= 1'b0; ml[s] <= 1'b0; md[s] <= 3'd0;
         end
         armed <= 1'b1;
      end else if (bus.advance) begin
         mv[2] <= mv[1]; mw[2] <= mw[1]; ml[2] <= ml[1]; md[2] <= md[1];
         mv[1] <= mv[0] & ~bus.flush; mw[1] <= mw[0]; ml[1] <= ml[0]; md[1] <= md[0];
         mv[0] <= bus.id_valid & ~bus.flush & ~exp_stall();
         mw[0] <= bus.id_reg_write; ml[0] <= bus.id_mem_read; md[0] <= bus.id_dest;
      end
   end
   always @(negedge clk) if (armed) begin
      #1;
      chk("stall_id", bus.stall_id, exp_stall());
      chk("pending", bus.pending, exp_pending());
      chk("ex_wr", bus.ex_wr, mv[0] & mw[0]);
      chk("mem_wr", bus.mem_wr, mv[1] & mw[1]);
      chk("wb_wr", bus.wb_wr, mv[2] & mw[2]);
      if (mv[0] && mw[0]) chk("ex_dest", bus.ex_dest, md[0]);
      if (mv[1] && mw[1]) chk("mem_dest", bus.mem_dest, md[1]);
      if (mv[2] && mw[2]) chk("wb_dest", bus.wb_dest, md[2]);
   end
   task automatic drive(input logic adv, fl, v, w, ld, input logic [2:0] d,
                        input logic u1, input logic [2:0] s1, input logic u2, input logic [2:0] s2);
      @(negedge clk);
      bus.advance = adv; bus.flush = fl; bus.id_valid = v; bus.id_reg_write = w;
      bus.id_mem_read = ld; bus.id_dest = d; bus.id_use_sr1 = u1; bus.id_sr1 = s1;
      bus.id_use_sr2 = u2; bus.id_sr2 = s2;
   endtask
   task automatic idle();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   initial begin
      bus.advance = 0; bus.flush = 0; bus.id_valid = 0; bus.id_reg_write = 0; bus.id_mem_read = 0;
      bus.id_dest = 0; bus.id_use_sr1 = 0; bus.id_sr1 = 0; bus.id_use_sr2 = 0; bus.id_sr2 = 0;
      idle();
      idle();
      reset = 0;
      idle();
      #2 chk("rst pending", bus.pending, 8'h00);
      chk("rst stall", bus.stall_id, 1'b0);
      chk("rst wr", {bus.ex_wr, bus.mem_wr, bus.wb_wr}, 3'b000);
      chk("rst dests", {bus.ex_dest, bus.mem_dest, bus.wb_dest}, 9'd0);
      repeat (3) idle();
      #2 chk("idle pending", bus.pending, 8'h00);
      // LDR R1 ; ADD R2,R1,R3
      drive(1, 0, 1, 1, 1, 3'd1, 1, 3'd0, 0, 3'd0);
      drive(1, 0, 1, 1, 0, 3'd2, 1, 3'd1, 1, 3'd3);
      #2 chk("lu stall", bus.stall_id, 1'b1);
      drive(1, 0, 1, 1, 0, 3'd2, 1, 3'd1, 1, 3'd3);
      #2 chk("lu stall drop", bus.stall_id, 1'b0);
      chk("lu bubble", bus.ex_wr, 1'b0);
      chk("lu ld in mem", bus.mem_dest, 3'd1);
      idle();
      #2 chk("lu add in ex", bus.ex_dest, 3'd2);
      chk("lu pending", bus.pending, 8'h06);
      idle();
      #2 chk("lu r1 retired", bus.pending, 8'h04);
      repeat (3) idle();
      // three writers to R1
      repeat (3) drive(1, 0, 1, 1, 0, 3'd1, 0, 3'd0, 0, 3'd0);
      idle();
      #2 chk("r1x3 pending", bus.pending, 8'h02);
      chk("r1x3 wr", {bus.ex_wr, bus.mem_wr, bus.wb_wr}, 3'b111);
      repeat (3) idle();
      #2 chk("r1x3 drained", bus.pending, 8'h00);
      // immediate form: sr2 matches load dest but is unused
      drive(1, 0, 1, 1, 1, 3'd4, 0, 3'd0, 0, 3'd0);
      drive(1, 0, 1, 1, 0, 3'd3, 1, 3'd0, 0, 3'd4);
      #2 chk("imm no stall", bus.stall_id, 1'b0);
      repeat (3) idle();
      // branch ; ADD R5 ; ADD R6 with flush
      drive(1, 0, 1, 0, 0, 3'd0, 0, 3'd0, 0, 3'd0);
      drive(1, 0, 1, 1, 0, 3'd5, 0, 3'd0, 0, 3'd0);
      drive(1, 1, 1, 1, 0, 3'd6, 0, 3'd0, 0, 3'd0);
      #2 chk("pre flush", bus.pending, 8'h20);
      idle();
      #2 chk("post flush pending", bus.pending, 8'h00);
      chk("post flush wr", {bus.ex_wr, bus.mem_wr}, 2'b00);
      // flush beats load-use
      drive(1, 0, 1, 1, 1, 3'd7, 0, 3'd0, 0, 3'd0);
      drive(1, 1, 1, 1, 0, 3'd2, 1, 3'd7, 0, 3'd0);
      #2 chk("flush over lu", bus.stall_id, 1'b0);
      idle();
      #2 chk("flush lu pending", bus.pending, 8'h00);
      // load-use held across a cache miss
      drive(1, 0, 1, 1, 1, 3'd2, 0, 3'd0, 0, 3'd0);
      repeat (4) begin
         drive(0, 0, 1, 1, 0, 3'd5, 1, 3'd2, 0, 3'd0);
         #2 chk("miss stall", bus.stall_id, 1'b1);
         chk("miss ex held", {bus.ex_wr, bus.ex_dest}, {1'b1, 3'd2});
      end
      drive(1, 0, 1, 1, 0, 3'd5, 1, 3'd2, 0, 3'd0);
      #2 chk("miss adv stall", bus.stall_id, 1'b1);
      drive(1, 0, 1, 1, 0, 3'd5, 1, 3'd2, 0, 3'd0);
      #2 chk("miss bubble", {bus.stall_id, bus.ex_wr}, 2'b00);
      // reset during a stall
      drive(1, 0, 1, 1, 1, 3'd3, 0, 3'd0, 0, 3'd0);
      drive(0, 0, 1, 1, 0, 3'd4, 0, 3'd0, 1, 3'd3);
      reset = 1;
      #2 chk("pre reset stall", bus.stall_id, 1'b1);
      drive(0, 0, 1, 1, 0, 3'd4, 0, 3'd0, 1, 3'd3);
      reset = 0;
      #2 chk("reset stall", bus.stall_id, 1'b0);
      chk("reset shadow", {bus.ex_wr, bus.mem_wr, bus.wb_wr, bus.pending}, 11'd0);
      repeat (600) begin
         logic adv;
         adv = ($urandom_range(0, 3) != 0);
         drive(adv, adv & ($urandom_range(0, 5) == 0), $urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 2) == 0, 3'($urandom), 1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom));
      end
      idle();
      #3 $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
